// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate sweep controller.
//   state_t      : controller states (IDLE, RUN, DONE)
//   MODE_*       : encodings of the mode input
//   TT_*         : expected truth tables, bit index = {a,b}
//   expected_tt  : mode -> expected 4-bit table
//   popcount4    : number of set bits in a 4-bit value
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_AND  = 2'd0;
  localparam logic [1:0] MODE_OR   = 2'd1;
  localparam logic [1:0] MODE_COMB = 2'd2;
  localparam logic [1:0] MODE_XOR  = 2'd3;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_COMB = 4'b1000;  // (a&b)&(a|b) reduces to a&b
  localparam logic [3:0] TT_XOR  = 4'b0110;

  function automatic logic [3:0] expected_tt(input logic [1:0] mode);
    logic [3:0] t;
    case (mode)
      MODE_AND:  t = TT_AND;
      MODE_OR:   t = TT_OR;
      MODE_COMB: t = TT_COMB;
      default:   t = TT_XOR;
    endcase
    return t;
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/sweep_settle_cnt.sv
// Loadable down-counter that times how long each vector is held.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : load load_val (has priority over dec)
//   load_val   : value loaded on load
//   dec        : decrement, saturating at zero
//   zero       : count is zero
module sweep_settle_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)               cnt <= '0;
    else if (load)            cnt <= load_val;
    else if (dec && !zero)    cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Drives a 2-input logic unit through vectors 00,01,10,11, holds each for
// SETTLE cycles, samples the unit output into a truth table and compares it
// with the expected table for the mode latched at start.
//   clk, rst_n     : clock, synchronous active-low reset
//   start, mode    : sweep request and expected function (sampled in IDLE)
//   dut_a, dut_b   : drive to the unit under check
//   dut_x          : unit output
//   busy, done     : sweep in progress / one-cycle result-valid pulse
//   pass, tt, err_cnt : result, held until the next accepted start
module gate_sweep_ctrl import gate_sweep_pkg::*; #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] mode,
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_x,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] tt,
  output logic [2:0] err_cnt
);

  localparam logic [CNT_W-1:0] LOAD_V = CNT_W'(SETTLE - 1);

  state_t     state, state_nx;
  logic [1:0] idx_q;    // current vector, doubles as the {a,b} drive
  logic [1:0] mode_q;
  logic [3:0] tt_q;
  logic       pass_q;
  logic [2:0] err_q;
  logic [2:0] err_now;
  logic       accept, last_vec, cnt_zero, cnt_load, cnt_dec;

  assign accept   = (state == IDLE) && start;
  assign last_vec = (idx_q == 2'd3);
  assign cnt_load = accept || ((state == RUN) && cnt_zero && !last_vec);
  assign cnt_dec  = (state == RUN);
  assign err_now  = popcount4(tt_q ^ expected_tt(mode_q));

  sweep_settle_cnt #(.CNT_W(CNT_W)) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (LOAD_V),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cnt_zero && last_vec) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // outputs; in DONE the compare result is shown live, then held from registers
  always_comb begin
    busy    = (state != IDLE);
    done    = (state == DONE);
    pass    = pass_q;
    err_cnt = err_q;
    if (state == DONE) begin
      pass    = (err_now == 3'd0);
      err_cnt = err_now;
    end
  end

  assign dut_a = idx_q[1];
  assign dut_b = idx_q[0];
  assign tt    = tt_q;

  // vector index, capture and result hold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q  <= 2'd0;
      mode_q <= 2'd0;
      tt_q   <= 4'd0;
      pass_q <= 1'b0;
      err_q  <= 3'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          idx_q  <= 2'd0;
          mode_q <= mode;
          tt_q   <= 4'd0;
          pass_q <= 1'b0;
          err_q  <= 3'd0;
        end
        RUN: if (cnt_zero) begin
          tt_q[idx_q] <= dut_x;
          if (!last_vec) idx_q <= idx_q + 2'd1;
        end
        DONE: begin
          idx_q  <= 2'd0;
          pass_q <= (err_now == 3'd0);
          err_q  <= err_now;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
module tb_gate_sweep_ctrl;

  localparam int SETTLE = 2;
  localparam int G_AND = 0, G_OR = 1, G_COMB = 2, G_XOR = 3, G_ONE = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance, SETTLE=2
  logic       start2 = 1'b0;
  logic [1:0] mode2 = 2'd0;
  int         gate2 = G_AND;
  logic       a2, b2, x2, busy2, done2, pass2;
  logic [3:0] tt2;
  logic [2:0] err2;

  // second instance, SETTLE=1, AND gate attached
  logic       start1 = 1'b0;
  logic [1:0] mode1 = 2'd0;
  logic       a1, b1, x1, busy1, done1, pass1;
  logic [3:0] tt1;
  logic [2:0] err1;

  function automatic logic gfn(input int g, input logic a, input logic b);
    case (g)
      G_AND:   return a & b;
      G_OR:    return a | b;
      G_COMB:  return (a & b) & (a | b);
      G_XOR:   return a ^ b;
      default: return 1'b1;
    endcase
  endfunction

  assign x2 = gfn(gate2, a2, b2);
  assign x1 = gfn(G_AND, a1, b1);

  gate_sweep_ctrl #(.SETTLE(SETTLE), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2),
    .dut_a(a2), .dut_b(b2), .dut_x(x2), .busy(busy2), .done(done2),
    .pass(pass2), .tt(tt2), .err_cnt(err2)
  );

  gate_sweep_ctrl #(.SETTLE(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1),
    .dut_a(a1), .dut_b(b1), .dut_x(x1), .busy(busy1), .done(done1),
    .pass(pass1), .tt(tt1), .err_cnt(err1)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One sweep on the SETTLE=2 instance with per-cycle vector checks.
  task automatic sweep(input int g, input logic [1:0] m, input logic [3:0] et,
                       input logic ep, input logic [2:0] ee);
    int k;
    bit got;
    @(posedge clk); #1 gate2 = g; mode2 = m; start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0; mode2 = ~m;  // late mode change must not matter
    k = 0; got = 0;
    while (!got && k <= 4*SETTLE + 4) begin
      @(negedge clk);
      if (done2) got = 1;
      else begin
        chk("vector", int'({a2, b2}), k / SETTLE);
        chk("busy_run", int'(busy2), 1);
        @(posedge clk);
        k++;
      end
    end
    if (!got) chk("done_timeout", 0, 1);
    else begin
      chk("latency", k, 4*SETTLE);
      chk("busy_done", int'(busy2), 1);
      chk("tt", int'(tt2), int'(et));
      chk("pass", int'(pass2), int'(ep));
      chk("err_cnt", int'(err2), int'(ee));
      @(posedge clk); @(negedge clk);
      chk("done_clr", int'(done2), 0);
      chk("busy_clr", int'(busy2), 0);
      chk("vec_idle", int'({a2, b2}), 0);
      chk("tt_hold", int'(tt2), int'(et));
      chk("pass_hold", int'(pass2), int'(ep));
      chk("err_hold", int'(err2), int'(ee));
    end
  endtask

  typedef struct {
    int         g;
    logic [1:0] m;
    logic [3:0] et;
    logic       ep;
    logic [2:0] ee;
  } vec_t;

  vec_t       tbl[6];
  logic [1:0] mseq[3];
  logic [2:0] eseq[3];

  initial begin
    tbl[0] = '{G_AND,  2'd0, 4'b1000, 1'b1, 3'd0};
    tbl[1] = '{G_OR,   2'd0, 4'b1110, 1'b0, 3'd2};
    tbl[2] = '{G_ONE,  2'd3, 4'b1111, 1'b0, 3'd2};
    tbl[3] = '{G_COMB, 2'd2, 4'b1000, 1'b1, 3'd0};
    tbl[4] = '{G_XOR,  2'd3, 4'b0110, 1'b1, 3'd0};
    tbl[5] = '{G_OR,   2'd1, 4'b1110, 1'b1, 3'd0};
    mseq[0] = 2'd0; mseq[1] = 2'd3; mseq[2] = 2'd1;
    eseq[0] = 3'd0; eseq[1] = 3'd3; eseq[2] = 3'd2;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy2), 0);
    chk("rst_done", int'(done2), 0);
    chk("rst_pass", int'(pass2), 0);
    chk("rst_tt", int'(tt2), 0);
    chk("rst_err", int'(err2), 0);
    chk("rst_vec", int'({a2, b2}), 0);
    chk("rst_busy1", int'(busy1), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // table-driven sweeps
    for (int i = 0; i < 6; i++)
      sweep(tbl[i].g, tbl[i].m, tbl[i].et, tbl[i].ep, tbl[i].ee);

    // reset while vector 10 is driven
    begin
      bit seen_done;
      @(posedge clk); #1 gate2 = G_OR; mode2 = 2'd1; start2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b0;
      repeat (2*SETTLE) @(posedge clk);
      @(negedge clk);
      chk("mid_vec", int'({a2, b2}), 2);
      chk("mid_tt", int'(tt2), 4'b0010);
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("mrst_busy", int'(busy2), 0);
      chk("mrst_done", int'(done2), 0);
      chk("mrst_tt", int'(tt2), 0);
      chk("mrst_pass", int'(pass2), 0);
      chk("mrst_err", int'(err2), 0);
      chk("mrst_vec", int'({a2, b2}), 0);
      seen_done = 0;
      repeat (12) begin
        @(negedge clk);
        if (done2 || busy2) seen_done = 1;
      end
      chk("mrst_quiet", int'(seen_done), 0);
      sweep(G_AND, 2'd0, 4'b1000, 1'b1, 3'd0);
    end

    // start held high: three back-to-back sweeps, mode toggled mid-run
    begin
      int cyc, last, sw;
      @(posedge clk); #1 gate2 = G_AND; mode2 = mseq[0]; start2 = 1'b1;
      cyc = 0; last = 0; sw = 0;
      while (sw < 3 && cyc < 100) begin
        @(negedge clk);
        if (sw > 0 && cyc == last + 1) chk("b2b_idle", int'(busy2), 0);
        if (sw > 0 && cyc == last + 2) chk("b2b_rerun", int'(busy2), 1);
        if (done2) begin
          chk("b2b_tt", int'(tt2), 4'b1000);
          chk("b2b_err", int'(err2), int'(eseq[sw]));
          chk("b2b_pass", int'(pass2), (eseq[sw] == 3'd0) ? 1 : 0);
          if (sw > 0) chk("b2b_gap", cyc - last, 4*SETTLE + 2);
          last = cyc;
          sw++;
        end
        @(posedge clk); #1;
        cyc++;
        if (sw == 3) start2 = 1'b0;
        else if (sw > 0 && cyc == last + 1) mode2 = mseq[sw];
        else if (cyc == last + 5) mode2 = ~mseq[sw];
      end
      if (sw < 3) chk("b2b_timeout", sw, 3);
      start2 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("b2b_stop", int'(busy2), 0);
    end

    // SETTLE=1 instance
    begin
      int k;
      bit got;
      @(posedge clk); #1 start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
      k = 0; got = 0;
      while (!got && k <= 8) begin
        @(negedge clk);
        if (done1) got = 1;
        else begin
          chk("s1_vector", int'({a1, b1}), k);
          @(posedge clk);
          k++;
        end
      end
      if (!got) chk("s1_timeout", 0, 1);
      else begin
        chk("s1_latency", k, 4);
        chk("s1_tt", int'(tt1), 4'b1000);
        chk("s1_pass", int'(pass1), 1);
        chk("s1_err", int'(err1), 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
